// File: rtl/ship_input_scheduler.sv
// Button front end for the spaceship game: synchronises and debounces four active-low
// buttons, runs rotate hold-to-repeat, and commits angle/weapon changes on frame boundaries.
module ship_input_scheduler #(
  parameter int DEBOUNCE_CYCLES     = 250000,
  parameter int REPEAT_DELAY_FRAMES = 20,
  parameter int REPEAT_RATE_FRAMES  = 6,
  parameter int NUM_WEAPONS         = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       Rotate_CW,
  input  logic       Rotate_CCW,
  input  logic       Weapon_switch,
  input  logic       Interaction,
  input  logic       frame_tick,
  output logic [3:0] SS_state,
  output logic [1:0] weapon_sel,
  output logic       interact_pulse,
  output logic       state_update
);

  localparam int DBW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FRMAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ? REPEAT_DELAY_FRAMES
                                                                     : REPEAT_RATE_FRAMES;
  localparam int FRW   = $clog2(FRMAX + 1);

  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0] DB_ZERO    = {DBW{1'b0}};
  localparam logic [DBW-1:0] DB_ONE     = DBW'(1);
  localparam logic [FRW-1:0] DELAY_LAST = FRW'(REPEAT_DELAY_FRAMES - 1);
  localparam logic [FRW-1:0] RATE_LAST  = FRW'(REPEAT_RATE_FRAMES - 1);
  localparam logic [FRW-1:0] FR_ZERO    = {FRW{1'b0}};
  localparam logic [FRW-1:0] FR_ONE     = FRW'(1);
  localparam logic [1:0]     WP_LAST    = 2'(NUM_WEAPONS - 1);
  localparam logic signed [2:0] PEND_MAX = 3'sd3;
  localparam logic signed [2:0] PEND_MIN = -3'sd3;

  localparam int BTN_CW  = 0;
  localparam int BTN_CCW = 1;
  localparam int BTN_WPN = 2;
  localparam int BTN_INT = 3;

  typedef enum logic [1:0] {RS_IDLE = 2'd0, RS_DELAY = 2'd1, RS_REPEAT = 2'd2} rep_state_t;

  logic [3:0]           raw_s, level_s, press_s;
  logic [3:0]           sync1_q, sync2_q;
  logic [3:0]           db_q, db_d;
  logic [3:0][DBW-1:0]  cnt_q, cnt_d;

  rep_state_t           state_q, state_d;
  logic                 dir_q, dir_d;
  logic [FRW-1:0]       fcnt_q, fcnt_d;
  logic                 cancel_s, step_up_s, step_dn_s;

  logic signed [2:0]    rot_pend_q, rot_pend_d, pend_base_s;
  logic                 wpn_pend_q, wpn_pend_d;
  logic [3:0]           ss_q, ss_d;
  logic [1:0]           wp_q, wp_d;
  logic                 upd_q, upd_d;
  logic                 int_q, int_d;

  assign raw_s   = {Interaction, Weapon_switch, Rotate_CCW, Rotate_CW};
  assign level_s = ~sync2_q;
  assign press_s = db_d & ~db_q;

  // Synchroniser and debounce state; the synchroniser resets to "released" so a held
  // button must still pass full debounce after reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      db_q    <= 4'h0;
      cnt_q   <= '{default: DB_ZERO};
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce: count cycles of disagreement, accept the new level once the count completes.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (level_s[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i]  = level_s[i];
          cnt_d[i] = DB_ZERO;
        end else begin
          cnt_d[i] = cnt_q[i] + DB_ONE;
        end
      end else begin
        cnt_d[i] = DB_ZERO;
      end
    end
  end

  assign cancel_s = dir_q ? (!db_d[BTN_CCW] || db_d[BTN_CW])
                          : (!db_d[BTN_CW]  || db_d[BTN_CCW]);

  // Repeat FSM state register (dir_q: 1 = CCW).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= RS_IDLE;
      dir_q   <= 1'b0;
      fcnt_q  <= FR_ZERO;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Repeat FSM next state: frame counting in DELAY/REPEAT, abort on release or opposite hold.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RS_IDLE: begin
        if (press_s[BTN_CW] && !db_d[BTN_CCW]) begin
          state_d = RS_DELAY;
          dir_d   = 1'b0;
          fcnt_d  = FR_ZERO;
        end else if (press_s[BTN_CCW] && !db_d[BTN_CW]) begin
          state_d = RS_DELAY;
          dir_d   = 1'b1;
          fcnt_d  = FR_ZERO;
        end else begin
          state_d = RS_IDLE;
        end
      end
      RS_DELAY: begin
        if (cancel_s) begin
          state_d = RS_IDLE;
          fcnt_d  = FR_ZERO;
        end else if (frame_tick) begin
          if (fcnt_q == DELAY_LAST) begin
            state_d = RS_REPEAT;
            fcnt_d  = FR_ZERO;
          end else begin
            fcnt_d  = fcnt_q + FR_ONE;
          end
        end else begin
          state_d = RS_DELAY;
        end
      end
      RS_REPEAT: begin
        if (cancel_s) begin
          state_d = RS_IDLE;
          fcnt_d  = FR_ZERO;
        end else if (frame_tick) begin
          if (fcnt_q == RATE_LAST) begin
            fcnt_d = FR_ZERO;
          end else begin
            fcnt_d = fcnt_q + FR_ONE;
          end
        end else begin
          state_d = RS_REPEAT;
        end
      end
      default: begin
        state_d = RS_IDLE;
        fcnt_d  = FR_ZERO;
      end
    endcase
  end

  // Repeat FSM outputs: one rotation step request per press or repeat interval.
  always_comb begin
    step_up_s = 1'b0;
    step_dn_s = 1'b0;
    case (state_q)
      RS_IDLE: begin
        if (press_s[BTN_CW] && !db_d[BTN_CCW]) begin
          step_dn_s = 1'b1;
        end else if (press_s[BTN_CCW] && !db_d[BTN_CW]) begin
          step_up_s = 1'b1;
        end else begin
          step_up_s = 1'b0;
        end
      end
      RS_DELAY: begin
        if (!cancel_s && frame_tick && (fcnt_q == DELAY_LAST)) begin
          step_up_s = dir_q;
          step_dn_s = ~dir_q;
        end else begin
          step_up_s = 1'b0;
        end
      end
      RS_REPEAT: begin
        if (!cancel_s && frame_tick && (fcnt_q == RATE_LAST)) begin
          step_up_s = dir_q;
          step_dn_s = ~dir_q;
        end else begin
          step_up_s = 1'b0;
        end
      end
      default: begin
        step_up_s = 1'b0;
      end
    endcase
  end

  // Frame commit uses pending values from before this cycle; new requests land afterwards.
  always_comb begin
    ss_d        = ss_q;
    wp_d        = wp_q;
    pend_base_s = rot_pend_q;
    rot_pend_d  = rot_pend_q;
    wpn_pend_d  = wpn_pend_q;
    if (frame_tick && (rot_pend_q != 3'sd0)) begin
      if (rot_pend_q[2]) begin
        ss_d        = ss_q - 4'd1;
        pend_base_s = rot_pend_q + 3'sd1;
      end else begin
        ss_d        = ss_q + 4'd1;
        pend_base_s = rot_pend_q - 3'sd1;
      end
    end else begin
      pend_base_s = rot_pend_q;
    end
    if (step_up_s && (pend_base_s != PEND_MAX)) begin
      rot_pend_d = pend_base_s + 3'sd1;
    end else if (step_dn_s && (pend_base_s != PEND_MIN)) begin
      rot_pend_d = pend_base_s - 3'sd1;
    end else begin
      rot_pend_d = pend_base_s;
    end
    if (frame_tick && wpn_pend_q) begin
      wp_d       = (wp_q == WP_LAST) ? 2'd0 : wp_q + 2'd1;
      wpn_pend_d = press_s[BTN_WPN];
    end else if (press_s[BTN_WPN]) begin
      wpn_pend_d = 1'b1;
    end else begin
      wpn_pend_d = wpn_pend_q;
    end
    upd_d = frame_tick && ((rot_pend_q != 3'sd0) || wpn_pend_q);
    int_d = press_s[BTN_INT];
  end

  // Pending requests and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rot_pend_q <= 3'sd0;
      wpn_pend_q <= 1'b0;
      ss_q       <= 4'd0;
      wp_q       <= 2'd0;
      upd_q      <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      rot_pend_q <= rot_pend_d;
      wpn_pend_q <= wpn_pend_d;
      ss_q       <= ss_d;
      wp_q       <= wp_d;
      upd_q      <= upd_d;
      int_q      <= int_d;
    end
  end

  assign SS_state       = ss_q;
  assign weapon_sel     = wp_q;
  assign state_update   = upd_q;
  assign interact_pulse = int_q;

endmodule

// File: doc/ship_input_scheduler.md
Name: ship_input_scheduler

Overview:
Converts the four raw active-low push-buttons into clean game-control state for the renderer. It drives the spaceship angle index and the weapon selection. Each button is synchronised and debounced. Rotation supports press plus hold-to-repeat. All angle and weapon changes are committed only on the frame boundary pulse from the VGA timing block, so a single frame never mixes two spaceship or weapon images. It sits between the board buttons and the pixel-selection logic in the top level, and replaces direct button-edge clocking of the spaceship state.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable CLK cycles required to accept a level change (~10 ms at 25.175 MHz)
REPEAT_DELAY_FRAMES, 20, frames a rotate button must be held before auto-repeat starts
REPEAT_RATE_FRAMES, 6, frames between auto-repeat steps
NUM_WEAPONS, 3, number of selectable weapons (range 2..4)

Ports:
CLK  input  1  pixel clock, 25.175 MHz
RESET  input  1  asynchronous active-low reset
Rotate_CW  input  1  raw button, active-low, asynchronous
Rotate_CCW  input  1  raw button, active-low, asynchronous
Weapon_switch  input  1  raw button, active-low, asynchronous
Interaction  input  1  raw button, active-low, asynchronous
frame_tick  input  1  one-cycle pulse at start of vertical blanking, synchronous to CLK
SS_state  output  4  spaceship angle index; 0 = 0 deg, +1 = +22.5 deg CCW
weapon_sel  output  2  current weapon, 0..NUM_WEAPONS-1
interact_pulse  output  1  one-cycle pulse per accepted Interaction press
state_update  output  1  one-cycle pulse on the cycle SS_state or weapon_sel changes

Behaviour:
- Reset (RESET=0, async):
  - SS_state=0, weapon_sel=0, interact_pulse=0, state_update=0.
  - All debounced levels = released; debounce counters=0.
  - Rotation pending=0; repeat FSM=IDLE; weapon pending=0.
  - Reset asserted mid-hold or mid-pending discards everything. After release, a button already held must still pass full debounce before it counts.
- Input path:
  - Per button: 2-FF synchroniser, then invert to active-high.
  - Per-button counter increments while the synced level differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - Counter width: clog2(DEBOUNCE_CYCLES+1).
  - Press event = debounced 0->1. Raw-pin-to-event latency = 2 + DEBOUNCE_CYCLES cycles.
- Rotation pending (rot_pend):
  - 3-bit signed, saturating at +3/-3.
  - CCW press/repeat: +1. CW press/repeat: -1. Saturate rather than wrap.
- Rotation repeat FSM (frame counter counts frame_tick pulses):
  - IDLE: exactly one of CW/CCW debounced-held and its press event -> add step, clear frame counter, go DELAY with dir latched.
  - DELAY: on frame_tick increment counter. At REPEAT_DELAY_FRAMES add one step in dir, clear counter, go REPEAT.
  - REPEAT: on frame_tick increment counter. At REPEAT_RATE_FRAMES add one step, clear counter.
  - DELAY/REPEAT: release of the dir button, or the other rotate button becoming held, -> IDLE with no step.
  - Both rotate buttons' press events in the same cycle: no step, stay IDLE.
- Commit on frame_tick:
  - If rot_pend != 0: SS_state <= SS_state + sign(rot_pend), modulo 16 (15+1=0, 0-1=15). rot_pend moves one toward 0. Exactly one step per frame.
  - If weapon pending: weapon_sel <= weapon_sel+1, wrapping NUM_WEAPONS-1 -> 0. Clear pending.
  - state_update=1 on that cycle iff either output changed.
- Weapon_switch:
  - A press sets the pending flag.
  - Multiple presses within one frame = one increment.
- Same-cycle ordering:
  - Commit uses the pending values registered before this cycle.
  - A press or repeat event in the same cycle as frame_tick lands in pending for the next frame. It is not lost and not applied early.
  - A weapon press coinciding with the frame_tick that clears pending re-sets pending.
- Interaction: interact_pulse=1 for exactly one cycle, the cycle after its press event. It is not frame-aligned.
- Held buttons never generate further press events except via the rotation repeat FSM.
- All outputs are registered.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_FRAMES=3, REPEAT_RATE_FRAMES=2, NUM_WEAPONS=3, frame_tick every 50 cycles.)
- Reset: hold RESET=0 with buttons bouncing -> SS_state=0, weapon_sel=0, no pulses. Release RESET with Rotate_CCW already low -> SS_state=1 only after 6 cycles of debounce plus the next frame_tick.
- Bounce: Rotate_CCW glitches low for 3 cycles, repeated 5 times, then stays high -> SS_state unchanged, state_update never asserted.
- Wrap and saturate:
  - SS_state=0, one clean CW press -> 15 on next frame_tick.
  - 4 CCW presses within one frame from 15 -> rot_pend saturates at 3; SS_state goes 0, 1, 2 over the next 3 frame_ticks, one step each.
- Hold-repeat: hold CCW for 10 frames from 0 -> SS_state=1 after frame 1, steps again at frames 4, 6, 8, 10 (final 5). Press CW while holding -> repeat stops, no step.
- Weapon wrap and coincidence:
  - Three Weapon_switch presses in separate frames -> weapon_sel 1, 2, 0.
  - Press event on the same cycle as frame_tick -> increment appears at the following frame_tick.
- Interaction: one clean press -> interact_pulse high exactly 1 cycle. A 100-cycle hold yields no second pulse.
